// File: rtl/div_unit_pkg.sv
// Shared types and constants for the multi-cycle integer divider.
// State encodings, handshake levels and the operand magnitude helper.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;
    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;

    localparam logic [5:0] DIV_ITERS = 6'd32;

    // Magnitude of a signed operand; unsigned operands pass through.
    function automatic logic [31:0] div_abs(input logic       is_signed,
                                            input logic [31:0] v);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Returns {remainder, quotient} after 32 iterations plus a sign fix-up.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divider_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        success_o
);

    div_state_e  state_q;
    logic [5:0]  cnt_q;
    logic [64:0] w_q;
    logic [31:0] divisor_q;
    logic        signed_q;
    logic        dsign_q;
    logic        vsign_q;
    logic [63:0] result_q;
    logic        success_q;

    logic [32:0] diff_d;
    logic [64:0] w_d;
    logic [31:0] quot_d;
    logic [31:0] rem_d;
    logic        abort_d;

    // One subtract/shift step and the final sign correction.
    always_comb begin
        diff_d  = {1'b0, w_q[63:32]} - {1'b0, divisor_q};
        w_d     = diff_d[32] ? {w_q[63:0], 1'b0}
                             : {diff_d[31:0], w_q[31:0], 1'b1};
        quot_d  = (signed_q && (dsign_q ^ vsign_q))
                ? (~w_q[31:0] + 32'd1) : w_q[31:0];
        rem_d   = (signed_q && dsign_q)
                ? (~w_q[64:33] + 32'd1) : w_q[64:33];
        abort_d = annul_i || (start_i == DIV_STOP);
    end

    // Sequencer: accept, iterate, fix up, hold result until start drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= 6'd0;
            w_q       <= 65'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            dsign_q   <= 1'b0;
            vsign_q   <= 1'b0;
            result_q  <= 64'd0;
            success_q <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (state_q)
                DIV_FREE: begin
                    if (start_i == DIV_START && !annul_i) begin
                        if (divider_i == 32'd0) begin
                            state_q <= DIV_BY_ZERO;
                        end else begin
                            state_q   <= DIV_ON;
                            cnt_q     <= 6'd0;
                            signed_q  <= signed_i;
                            dsign_q   <= dividend_i[31];
                            vsign_q   <= divider_i[31];
                            divisor_q <= div_abs(signed_i, divider_i);
                            // Dividend sits one bit up so the first
                            // compare already sees its MSB.
                            w_q <= {32'd0,
                                    div_abs(signed_i, dividend_i),
                                    1'b0};
                        end
                    end
                end
                DIV_BY_ZERO: begin
                    result_q <= 64'd0;
                    if (abort_d) begin
                        state_q   <= DIV_FREE;
                        success_q <= DIV_RESULT_NOT_READY;
                    end else begin
                        state_q   <= DIV_END;
                        success_q <= DIV_RESULT_READY;
                    end
                end
                DIV_ON: begin
                    if (abort_d) begin
                        state_q   <= DIV_FREE;
                        result_q  <= 64'd0;
                        success_q <= DIV_RESULT_NOT_READY;
                    end else if (cnt_q < DIV_ITERS) begin
                        w_q   <= w_d;
                        cnt_q <= cnt_q + 6'd1;
                    end else begin
                        result_q  <= {rem_d, quot_d};
                        success_q <= DIV_RESULT_READY;
                        state_q   <= DIV_END;
                    end
                end
                DIV_END: begin
                    if (abort_d) begin
                        state_q   <= DIV_FREE;
                        result_q  <= 64'd0;
                        success_q <= DIV_RESULT_NOT_READY;
                    end
                end
                default: begin
                    state_q <= DIV_FREE;
                end
            endcase
        end
    end

    assign result_o  = result_q;
    assign success_o = success_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed cases plus random traffic.
// A cycle-level behavioural model is compared against the DUT every cycle.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_i;
    logic [31:0] dividend_i;
    logic [31:0] divider_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        success_o;

    always #5 clk = ~clk;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .signed_i   (signed_i),
        .dividend_i (dividend_i),
        .divider_i  (divider_i),
        .start_i    (start_i),
        .annul_i    (annul_i),
        .result_o   (result_o),
        .success_o  (success_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference arithmetic: truncating division, {rem, quot}.
    function automatic logic [63:0] ref_div(input logic s,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q, r;
        int sa, sb;
        if (b == 32'd0) return 64'd0;
        if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
        return {r, q};
    endfunction

    // Behavioural timing model: a countdown from acceptance to result.
    typedef enum {M_IDLE, M_BUSY, M_DONE} mph_e;
    mph_e        mph      = M_IDLE;
    int          rem_cyc  = 0;
    logic [63:0] pend     = 64'd0;
    logic [63:0] exp_res  = 64'd0;
    logic        exp_succ = 1'b0;
    bit          cmp_en   = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            mph      <= M_IDLE;
            exp_succ <= 1'b0;
            exp_res  <= 64'd0;
        end else begin
            case (mph)
                M_IDLE: if (start_i && !annul_i) begin
                    pend    <= ref_div(signed_i, dividend_i, divider_i);
                    rem_cyc <= (divider_i == 32'd0) ? 1 : 33;
                    mph     <= M_BUSY;
                end
                M_BUSY: begin
                    if (annul_i || !start_i) begin
                        mph <= M_IDLE;
                    end else if (rem_cyc == 1) begin
                        exp_succ <= 1'b1;
                        exp_res  <= pend;
                        mph      <= M_DONE;
                    end else begin
                        rem_cyc <= rem_cyc - 1;
                    end
                end
                M_DONE: if (annul_i || !start_i) begin
                    mph      <= M_IDLE;
                    exp_succ <= 1'b0;
                    exp_res  <= 64'd0;
                end
                default: mph <= M_IDLE;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            chk("model_success", {63'd0, success_o}, {63'd0, exp_succ});
            chk("model_result", result_o, exp_res);
        end
    end

    task automatic run(input logic s, input logic [31:0] a,
                       input logic [31:0] b, input bit lit,
                       input logic [63:0] lit_res, input string name);
        int cyc;
        bit seen;
        signed_i   = s;
        dividend_i = a;
        divider_i  = b;
        start_i    = 1'b1;
        annul_i    = 1'b0;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            dividend_i = $urandom;
            divider_i  = $urandom;
            signed_i   = 1'($urandom);
            if (success_o) seen = 1'b1;
        end
        chk({name, "_done"}, {63'd0, seen}, 64'd1);
        if (lit) begin
            chk({name, "_latency"}, 64'(cyc), (b == 32'd0) ? 64'd2 : 64'd34);
            chk({name, "_result"}, result_o, lit_res);
        end
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_drop"}, {63'd0, success_o}, 64'd0);
    endtask

    task automatic abort_run(input logic s, input logic [31:0] a,
                             input logic [31:0] b, input int k,
                             input bit use_annul, input string name);
        bit any;
        signed_i   = s;
        dividend_i = a;
        divider_i  = b;
        start_i    = 1'b1;
        annul_i    = 1'b0;
        repeat (k) begin
            @(posedge clk);
            #1;
        end
        if (use_annul) annul_i = 1'b1;
        else start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        start_i = 1'b0;
        any = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (success_o) any = 1'b1;
        end
        chk({name, "_no_success"}, {63'd0, any}, 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        signed_i   = 1'b0;
        dividend_i = 32'd0;
        divider_i  = 32'd0;
        start_i    = 1'b0;
        annul_i    = 1'b0;

        chk("pin_s_m7_2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2),
            {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("pin_s_7_m2", ref_div(1'b1, 32'd7, 32'hFFFF_FFFE),
            {32'd1, 32'hFFFF_FFFD});
        chk("pin_u_100_7", ref_div(1'b0, 32'd100, 32'd7),
            {32'd2, 32'd14});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result_o, 64'd0);
        chk("reset_success", {63'd0, success_o}, 64'd0);
        rst    = 1'b0;
        cmp_en = 1'b1;

        run(1'b0, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14}, "u100_7");
        run(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "s_m7_2");
        run(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1,
            {32'd1, 32'hFFFF_FFFD}, "s_7_m2");
        run(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1,
            {32'd0, 32'hFFFF_FFFF}, "u_max_1");
        run(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1,
            {32'd1, 32'h7FFF_FFFC}, "u_big_2");
        run(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1,
            {32'd0, 32'h8000_0000}, "s_min_m1");
        run(1'b0, 32'd12345, 32'd0, 1'b1, 64'd0, "u_div0");
        run(1'b1, 32'hFFFF_0000, 32'd0, 1'b1, 64'd0, "s_div0");

        abort_run(1'b0, 32'd123456, 32'd77, 11, 1'b1, "annul_it10");

        signed_i   = 1'b0;
        dividend_i = 32'd999;
        divider_i  = 32'd5;
        start_i    = 1'b1;
        repeat (21) begin
            @(posedge clk);
            #1;
        end
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_result", result_o, 64'd0);
        chk("rst_mid_success", {63'd0, success_o}, 64'd0);
        rst = 1'b0;
        run(1'b0, 32'd64, 32'd8, 1'b1, {32'd0, 32'd8}, "restart_64_8");
        run(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1,
            {32'hFFFF_FFFE, 32'hFFFF_FFF2}, "b2b_m100_7");

        for (int i = 0; i < 40; i++) begin
            logic        s;
            logic [31:0] a, b;
            int          sel, k;
            s   = 1'($urandom);
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) b = 32'hFFFF_FFFF;
            else if (sel == 2) b = 32'($urandom_range(1, 15));
            else b = $urandom;
            if ($urandom_range(0, 5) == 0) a = 32'h8000_0000;
            if ($urandom_range(0, 5) == 0) begin
                k = (b == 32'd0) ? 1 : $urandom_range(1, 30);
                abort_run(s, a, b, k, 1'($urandom), "rnd_abort");
            end else begin
                run(s, a, b, 1'b0, 64'd0, "rnd");
            end
        end

        repeat (2) @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
